// File: rtl/nor_equiv_checker.sv
// Sweeps every N_IN-bit vector into two gate implementations and checks both
// responses against each other and a golden N-input NOR; counts and captures failures.
module nor_equiv_checker #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = N_IN + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  vec,
  input  logic             resp_a,
  input  logic             resp_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_valid
);

  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0]  ffv_q, ffv_d;
  logic             ffvld_q, ffvld_d;
  logic [SC_W-1:0]  settle_q, settle_d;
  logic             golden;
  logic             mismatch;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    cnt_d    = cnt_q;
    ffv_d    = ffv_q;
    ffvld_d  = ffvld_q;
    settle_d = settle_q;
    golden   = ~|vec_q;
    mismatch = (resp_a != resp_b) || (resp_a != golden) || (resp_b != golden);

    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d    = '0;
          cnt_d    = '0;
          pass_d   = 1'b0;
          ffv_d    = '0;
          ffvld_d  = 1'b0;
          settle_d = '0;
          busy_d   = 1'b1;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        settle_d = settle_q + SC_W'(1);
        if (settle_q == SC_W'(SETTLE_CYCLES - 1)) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (mismatch) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          if (!ffvld_q) begin
            ffv_d   = vec_q;
            ffvld_d = 1'b1;
          end
        end
        // Last vector: results are published together with the done pulse.
        if (&vec_q) begin
          vec_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (cnt_d == '0);
          state_d = DONE;
        end else begin
          vec_d    = vec_q + N_IN'(1);
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      cnt_q    <= '0;
      ffv_q    <= '0;
      ffvld_q  <= 1'b0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      cnt_q    <= cnt_d;
      ffv_q    <= ffv_d;
      ffvld_q  <= ffvld_d;
      settle_q <= settle_d;
    end
  end

  assign vec              = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign mismatch_cnt     = cnt_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvld_q;

endmodule
